// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath definitions: word width, memory-interface FSM states and defaults.
package lc3_pkg;

    localparam int LC3_WORD = 16;
    localparam int TIMEOUT_DEFAULT = 64;
    localparam logic [LC3_WORD-1:0] FAULT_DATA_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/lc3_mem_watchdog.sv
// Cycle counter that flags when an access has waited TIMEOUT cycles; shared by memory and I/O stages.
module lc3_mem_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_reg;

    assign expired = (cnt_reg == LAST);

    // Saturates at LAST so a stalled owner keeps seeing expired until it clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable && !expired) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR memory interface: bus-loaded address/data registers and a req/ack access FSM.
module lc3_mem_if
    import lc3_pkg::*;
#(
    parameter int                    TIMEOUT    = TIMEOUT_DEFAULT,
    parameter logic [LC3_WORD-1:0]   FAULT_DATA = FAULT_DATA_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    inout  wire  [LC3_WORD-1:0]  main_bus,
    input  logic                 LDMAR,
    input  logic                 LDMDR,
    input  logic                 GateMDR,
    input  logic                 MIO_EN,
    input  logic                 R_W,
    output logic                 R,
    output logic [LC3_WORD-1:0]  mem_addr,
    output logic [LC3_WORD-1:0]  mem_wdata,
    output logic                 mem_we,
    output logic                 mem_req,
    input  logic [LC3_WORD-1:0]  mem_rdata,
    input  logic                 mem_ack,
    output logic                 mem_fault
);

    mem_state_t          state_reg;
    logic [LC3_WORD-1:0] mar_reg;
    logic [LC3_WORD-1:0] mdr_reg;
    logic [LC3_WORD-1:0] rd_buf_reg;
    logic                wd_expired;

    assign main_bus = GateMDR ? mdr_reg : 'z;

    lc3_mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg == IDLE),
        .enable  ((state_reg == REQ) && !mem_ack),
        .expired (wd_expired)
    );

    // Memory read data only reaches MDR in the completion cycle; otherwise MDR holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mar_reg <= '0;
            mdr_reg <= '0;
        end else begin
            if (LDMAR) begin
                mar_reg <= main_bus;
            end
            if (LDMDR) begin
                if (!MIO_EN) begin
                    mdr_reg <= main_bus;
                end else if (state_reg == DONE) begin
                    mdr_reg <= rd_buf_reg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            R          <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_fault  <= 1'b0;
            rd_buf_reg <= '0;
        end else begin
            R <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (MIO_EN) begin
                        mem_addr  <= mar_reg;
                        mem_wdata <= mdr_reg;
                        mem_we    <= R_W;
                        mem_req   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    // An ack arriving on the expiry cycle wins: real data, no fault.
                    if (mem_ack || wd_expired) begin
                        if (!mem_we) begin
                            rd_buf_reg <= mem_ack ? mem_rdata : FAULT_DATA;
                        end
                        if (!mem_ack) begin
                            mem_fault <= 1'b1;
                        end
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        R         <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
